// File: rtl/aes_sub_bytes_ctrl.sv
// SubBytes stage controller: streams a state block one word per cycle through the
// shared S-box lookup and reassembles the substituted block for ShiftRows.
module aes_sub_bytes_ctrl #(
  parameter int BLOCK_W   = 128,
  parameter int WORD_W    = 32,
  parameter int NUM_WORDS = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               sbox_available,
  input  logic [BLOCK_W-1:0] state_in,
  input  logic               state_in_vld,
  output logic               state_in_rdy,
  output logic [WORD_W-1:0]  sub_bytes_val,
  output logic               sub_bytes_val_vld,
  input  logic [WORD_W-1:0]  sub_bytes_sbox_data,
  input  logic               sub_bytes_sbox_data_vld,
  output logic [BLOCK_W-1:0] state_out,
  output logic               state_out_vld,
  output logic               busy
);

  localparam int CNT_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(NUM_WORDS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SUB  = 2'd1,
    DONE = 2'd2
  } fsm_e;

  fsm_e               fsm_q, fsm_d;
  logic               sbox_loaded_q, sbox_loaded_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [BLOCK_W-1:0] in_q, in_d;
  logic [BLOCK_W-1:0] res_q, res_d;
  logic [BLOCK_W-1:0] state_out_q, state_out_d;

  // Word 0 sits in the most significant bits of the block.
  function automatic logic [WORD_W-1:0] word_sel(input logic [BLOCK_W-1:0] blk,
                                                 input logic [CNT_W-1:0] idx);
    return blk[BLOCK_W-1-WORD_W*int'(idx) -: WORD_W];
  endfunction

  always_comb begin
    fsm_d         = fsm_q;
    sbox_loaded_d = sbox_loaded_q;
    cnt_d         = cnt_q;
    in_d          = in_q;
    res_d         = res_q;
    state_out_d   = state_out_q;

    // Reloads of the table only ever keep the flag set.
    if (sbox_available) sbox_loaded_d = 1'b1;

    case (fsm_q)
      IDLE: begin
        if (state_in_vld && sbox_loaded_q) begin
          in_d  = state_in;
          cnt_d = '0;
          fsm_d = SUB;
        end
      end
      SUB: begin
        if (sub_bytes_sbox_data_vld) begin
          res_d[BLOCK_W-1-WORD_W*int'(cnt_q) -: WORD_W] = sub_bytes_sbox_data;
          if (cnt_q == LAST_WORD) begin
            state_out_d = res_d;
            cnt_d       = '0;
            fsm_d       = DONE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      DONE:    fsm_d = IDLE;
      default: fsm_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fsm_q         <= IDLE;
      sbox_loaded_q <= 1'b0;
      cnt_q         <= '0;
      state_out_q   <= '0;
    end else begin
      fsm_q         <= fsm_d;
      sbox_loaded_q <= sbox_loaded_d;
      cnt_q         <= cnt_d;
      state_out_q   <= state_out_d;
    end
  end

  // Working block registers are fully rewritten before use, so they need no reset.
  always_ff @(posedge clk) begin
    in_q  <= in_d;
    res_q <= res_d;
  end

  // All outputs decode registered state only; nothing passes through from inputs.
  assign state_in_rdy      = (fsm_q == IDLE) && sbox_loaded_q;
  assign sub_bytes_val_vld = (fsm_q == SUB);
  assign sub_bytes_val     = (fsm_q == SUB) ? word_sel(in_q, cnt_q) : '0;
  assign state_out         = state_out_q;
  assign state_out_vld     = (fsm_q == DONE);
  assign busy              = (fsm_q == SUB) || (fsm_q == DONE);

endmodule

// File: doc/aes_sub_bytes_ctrl.md
Name: aes_sub_bytes_ctrl

Overview:
SubBytes stage controller for the AES-128 datapath. It accepts a 128-bit state block and streams its four 32-bit words, one per cycle, to the sub_bytes port of the shared word-wide S-box lookup. It collects the substituted words and presents the full substituted block to the downstream ShiftRows stage. It also tracks whether the S-box table has been loaded and refuses work until it has.

Parameters:
BLOCK_W, 128, state block width in bits
WORD_W, 32, width of one S-box request word (must equal the codebase WORD_DATA_WIDTH)
NUM_WORDS, 4, words per block (BLOCK_W/WORD_W)

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
sbox_available  input  1  one-cycle pulse from S-box block: table written
state_in  input  BLOCK_W  block to substitute; word 0 = [127:96], word 3 = [31:0]
state_in_vld  input  1  state_in valid
state_in_rdy  output  1  block can accept state_in this cycle
sub_bytes_val  output  WORD_W  word sent to S-box
sub_bytes_val_vld  output  1  S-box request valid
sub_bytes_sbox_data  input  WORD_W  substituted word from S-box (same-cycle response)
sub_bytes_sbox_data_vld  input  1  substituted word valid
state_out  output  BLOCK_W  substituted block, same word ordering as state_in
state_out_vld  output  1  one-cycle pulse: state_out valid
busy  output  1  high in SUB or DONE

Behaviour:
- Reset (sync, active-high) values: FSM=IDLE, sbox_loaded=0, word counter=0, state_in_rdy=0, sub_bytes_val=0, sub_bytes_val_vld=0, state_out=0, state_out_vld=0, busy=0.
- sbox_loaded flag: set on any cycle sampling sbox_available=1; cleared only by reset. Later sbox_available pulses (table reload) have no other effect, including mid-operation.
- FSM states: IDLE, SUB, DONE.
- IDLE: state_in_rdy = sbox_loaded. On state_in_vld && state_in_rdy, latch state_in into the input register, counter=0, go to SUB. state_in_vld while not loaded is ignored; no latch.
- SUB: sub_bytes_val = input word[counter] (counter 0 selects [127:96]); sub_bytes_val_vld=1. Both are driven from registers and counter only, with no combinational path from any input.
- SUB, capture: on a cycle with sub_bytes_sbox_data_vld=1, write sub_bytes_sbox_data into result word[counter] and increment counter. If sub_bytes_sbox_data_vld=0, hold counter and request (stall).
- SUB, exit: capture at counter=3 loads the result register into state_out and goes to DONE. Counter wraps to 0.
- DONE: state_out_vld=1 for exactly one cycle, then IDLE. state_in_rdy=0 in SUB and DONE.
- sub_bytes_val=0 and sub_bytes_val_vld=0 whenever not in SUB.
- state_out holds its value until the next block completes. state_out_vld deasserts after the DONE cycle.
- Latency with no stall: accept at edge T, requests during cycles T+1..T+4, state_out_vld high in cycle T+5, state_in_rdy high again from T+6. Throughput is 1 block per 6 cycles.
- Reset mid-SUB or mid-DONE: immediate return to reset values. No state_out_vld pulse. Partial result discarded. sbox_loaded cleared.
- sbox_available and accept in the same cycle: accept is not taken, because rdy derives from the registered flag. Accept becomes possible the following cycle.

Test Plan:
- No sbox_available after reset, state_in_vld=1 for 20 cycles -> state_in_rdy=0, sub_bytes_val_vld never asserted, no state_out_vld.
- Standard AES S-box loaded, state_in=00112233445566778899aabbccddeeff -> requests 00112233, 44556677, 8899aabb, ccddeeff in consecutive cycles; state_out=638293c31bfc33f5c4eeacea4bc12816, state_out_vld exactly 5 cycles after accept.
- sub_bytes_sbox_data_vld forced low for 3 cycles during word 2 -> request 8899aabb held for 3 extra cycles; final result unchanged; state_out_vld delayed by 3.
- Two back-to-back blocks (all-00 then all-ff) with state_in_vld held high -> outputs 63636363... then 16161616...; second accept occurs 6 cycles after the first.
- reset asserted during word 1 -> next cycle all outputs 0 and state_in_rdy=0; after a new sbox_available pulse, the next block completes correctly.
- Second sbox_available pulse mid-SUB -> operation completes normally with no extra or missing state_out_vld.
